// File: rtl/mcu_sequencer_pkg.sv
// Shared definitions for the 8-bit MCU sequencer.
//   - opcode values carried in instr[7:4]
//   - ALU operation encodings driven on alu_op
//   - sequencer state encoding
//   - instruction classes produced by the decoder
package mcu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP = 3'd0,
        CL_ALU = 3'd1,
        CL_LD  = 3'd2,
        CL_ST  = 3'd3,
        CL_JMP = 3'd4,
        CL_JZ  = 3'd5,
        CL_HLT = 3'd6
    } op_class_e;

endpackage

// File: rtl/mcu_sequencer_if.sv
// Control/handshake bundle between the MCU sequencer and the datapath/memory.
//   master : sequencer side (drives strobes and mux selects)
//   slave  : datapath/memory side (drives run, instr, mem_ready, zero)
// Signals:
//   run        level request to execute
//   instr[7:0] instruction byte from program memory
//   mem_ready  memory access complete
//   zero       ALU zero flag
//   MA, MB     bus-A / bus-B mux selects
//   ir_load, pc_inc, pc_load, alu_op[2:0], reg_we, mem_rd, mem_wr  datapath strobes
//   halted, fault  status
interface mcu_sequencer_if;

    logic       run;
    logic [7:0] instr;
    logic       mem_ready;
    logic       zero;

    logic       MA;
    logic       MB;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       fault;

    modport master (
        input  run, instr, mem_ready, zero,
        output MA, MB, ir_load, pc_inc, pc_load, alu_op,
               reg_we, mem_rd, mem_wr, halted, fault
    );

    modport slave (
        output run, instr, mem_ready, zero,
        input  MA, MB, ir_load, pc_inc, pc_load, alu_op,
               reg_we, mem_rd, mem_wr, halted, fault
    );

endinterface

// File: rtl/mcu_sequencer_decode.sv
// Combinational opcode decoder for the MCU sequencer.
// Ports:
//   i_opcode  [OPW-1:0]  opcode field of the latched instruction
//   o_class              instruction class steering the sequencer
//   o_alu_op             ALU operation for ALU-class instructions (pass-A otherwise)
//   o_illegal            opcode not in the instruction set (class reported as HLT)
module mcu_decode
    import mcu_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    output op_class_e      o_class,
    output alu_op_e        o_alu_op,
    output logic           o_illegal
);

    logic [3:0] w_op;

    assign w_op = 4'(i_opcode);

    always_comb begin
        o_class   = CL_HLT;
        o_alu_op  = ALU_PASS;
        o_illegal = 1'b0;
        case (w_op)
            OP_NOP: o_class = CL_NOP;
            OP_ADD: begin
                o_class  = CL_ALU;
                o_alu_op = ALU_ADD;
            end
            OP_SUB: begin
                o_class  = CL_ALU;
                o_alu_op = ALU_SUB;
            end
            OP_AND: begin
                o_class  = CL_ALU;
                o_alu_op = ALU_AND;
            end
            OP_OR: begin
                o_class  = CL_ALU;
                o_alu_op = ALU_OR;
            end
            OP_LD:  o_class = CL_LD;
            OP_ST:  o_class = CL_ST;
            OP_JMP: o_class = CL_JMP;
            OP_JZ:  o_class = CL_JZ;
            OP_HLT: o_class = CL_HLT;
            // Unknown opcodes halt the machine and raise fault.
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcu_sequencer.sv
// Control FSM for the 8-bit MCU datapath: fetch / decode / execute / memory /
// writeback, one instruction in flight. All outputs are registered and take
// the value belonging to the state being entered.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mcu_sequencer_if.master: run/instr/mem_ready/zero in,
//          MA/MB/ir_load/pc_inc/pc_load/alu_op/reg_we/mem_rd/mem_wr/halted/fault out
// Parameters:
//   OPW     opcode width (instr[7 -: OPW])
//   MEM_TO  mem_ready wait-cycle limit in FETCH/MEM before fault
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int unsigned OPW    = 4,
    parameter int unsigned MEM_TO = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mcu_sequencer_if.master        bus
);

    localparam int unsigned          CNT_W   = $clog2(MEM_TO + 1);
    localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(MEM_TO - 1);

    state_e           r_state;
    logic [OPW-1:0]   r_opcode;
    logic             r_imm_sel;
    logic             r_run_d;
    logic [CNT_W-1:0] r_to_cnt;

    logic             r_ma;
    logic             r_mb;
    logic             r_ir_load;
    logic             r_pc_inc;
    logic             r_pc_load;
    alu_op_e          r_alu_op;
    logic             r_reg_we;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic             r_halted;
    logic             r_fault;

    op_class_e        w_class;
    alu_op_e          w_alu_op;
    logic             w_illegal;
    logic             w_unused_imm_bits;

    // Only the opcode and the immediate-select bit steer the sequencer; the
    // remaining immediate bits go straight to the datapath.
    assign w_unused_imm_bits = ^bus.instr[2:0];

    mcu_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_opcode  (r_opcode),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_opcode  <= '0;
            r_imm_sel <= 1'b0;
            r_run_d   <= 1'b0;
            r_to_cnt  <= '0;
            r_ma      <= 1'b0;
            r_mb      <= 1'b0;
            r_ir_load <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_pc_load <= 1'b0;
            r_alu_op  <= ALU_PASS;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_run_d <= bus.run;

            // Every output is recomputed for the state being entered; the
            // branches below only raise what that state needs.
            r_ma      <= 1'b0;
            r_mb      <= 1'b0;
            r_ir_load <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_pc_load <= 1'b0;
            r_alu_op  <= ALU_PASS;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_halted  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                        r_ma     <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_opcode  <= bus.instr[7 -: OPW];
                        r_imm_sel <= bus.instr[3];
                        r_ir_load <= 1'b1;
                        r_pc_inc  <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= S_DECODE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_to_cnt <= '0;
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        r_mem_rd <= 1'b1;
                        r_ma     <= 1'b1;
                    end
                end

                S_DECODE: begin
                    case (w_class)
                        CL_NOP: begin
                            if (bus.run) begin
                                r_state  <= S_FETCH;
                                r_mem_rd <= 1'b1;
                                r_ma     <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        CL_ALU: begin
                            r_state  <= S_EXEC;
                            r_alu_op <= w_alu_op;
                            r_mb     <= r_imm_sel;
                        end
                        CL_LD: begin
                            r_state  <= S_MEM;
                            r_mem_rd <= 1'b1;
                        end
                        CL_ST: begin
                            r_state  <= S_MEM;
                            r_mem_wr <= 1'b1;
                        end
                        CL_JMP: begin
                            r_state   <= S_EXEC;
                            r_pc_load <= 1'b1;
                        end
                        CL_JZ: begin
                            // Registered outputs: the flag is taken on the edge
                            // into EXEC, while no ALU operation is in flight.
                            r_state   <= S_EXEC;
                            r_pc_load <= bus.zero;
                        end
                        CL_HLT: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            if (w_illegal) begin
                                r_fault <= 1'b1;
                            end
                        end
                        default: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            r_fault  <= 1'b1;
                        end
                    endcase
                end

                S_EXEC: begin
                    if (w_class == CL_ALU) begin
                        // ALU select and operand mux stay put so the result
                        // being written back remains stable.
                        r_state  <= S_WB;
                        r_reg_we <= 1'b1;
                        r_alu_op <= r_alu_op;
                        r_mb     <= r_mb;
                    end else if (bus.run) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                        r_ma     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_to_cnt <= '0;
                        if (w_class == CL_LD) begin
                            r_state  <= S_WB;
                            r_reg_we <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                            r_mem_rd <= 1'b1;
                            r_ma     <= 1'b1;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_to_cnt <= '0;
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        r_mem_rd <= (w_class == CL_LD);
                        r_mem_wr <= (w_class == CL_ST);
                    end
                end

                S_WB: begin
                    if (bus.run) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                        r_ma     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_HALT: begin
                    // Resume needs a fresh rising edge of run and no fault.
                    if (!r_fault && bus.run && !r_run_d) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                        r_ma     <= 1'b1;
                    end else begin
                        r_halted <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.MA      = r_ma;
    assign bus.MB      = r_mb;
    assign bus.ir_load = r_ir_load;
    assign bus.pc_inc  = r_pc_inc;
    assign bus.pc_load = r_pc_load;
    assign bus.alu_op  = r_alu_op;
    assign bus.reg_we  = r_reg_we;
    assign bus.mem_rd  = r_mem_rd;
    assign bus.mem_wr  = r_mem_wr;
    assign bus.halted  = r_halted;
    assign bus.fault   = r_fault;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Directed self-checking bench for mcu_sequencer (MEM_TO = 15).
// Output vector layout: {MA, MB, ir_load, pc_inc, pc_load, alu_op[2:0],
//                        reg_we, mem_rd, mem_wr, halted, fault}
module tb_mcu_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    mcu_sequencer_if bus ();

    mcu_sequencer #(
        .OPW    (4),
        .MEM_TO (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [12:0] outs;
    assign outs = {bus.MA, bus.MB, bus.ir_load, bus.pc_inc, bus.pc_load, bus.alu_op,
                   bus.reg_we, bus.mem_rd, bus.mem_wr, bus.halted, bus.fault};

    //                              MA MB IL PI PL | ALU | WE RD WR H F
    localparam logic [12:0] O_IDLE  = 13'b00000_000_00000;
    localparam logic [12:0] O_FETCH = 13'b10000_000_01000;
    localparam logic [12:0] O_DEC   = 13'b00110_000_00000;
    localparam logic [12:0] O_LD    = 13'b00000_000_01000;
    localparam logic [12:0] O_ST    = 13'b00000_000_00100;
    localparam logic [12:0] O_JUMP  = 13'b00001_000_00000;
    localparam logic [12:0] O_ADD_R = 13'b00000_001_00000;
    localparam logic [12:0] O_SUB_I = 13'b01000_010_00000;
    localparam logic [12:0] O_WB_LD = 13'b00000_000_10000;
    localparam logic [12:0] O_HALT  = 13'b00000_000_00010;
    localparam logic [12:0] O_HALTF = 13'b00000_000_00011;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle-level invariants on the control strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ((bus.pc_inc && bus.pc_load) || (bus.mem_rd && bus.mem_wr) ||
                (bus.MA && !(bus.mem_rd && !bus.mem_wr)) ||
                (bus.halted && (bus.mem_rd || bus.mem_wr || bus.reg_we ||
                                bus.ir_load || bus.pc_inc || bus.pc_load))) begin
                n_fail++;
                $display("FAIL invariant at %0t: got %b (strobes must be exclusive, MA only while fetching)",
                         $time, outs);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.instr     = 8'h00;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL reset_state: got %b want %b", outs, O_IDLE); end
        step();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL idle_no_run: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_alu();
        logic [8:0] wb;
        do_reset();
        bus.run   = 1'b1;
        bus.instr = 8'h13;
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL alu_fetch: got %b want %b", outs, O_FETCH); end
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL alu_fetch_wait: got %b want %b", outs, O_FETCH); end
        bus.mem_ready = 1'b1;
        step();
        n_cmp++;
        if (outs !== O_DEC) begin n_fail++; $display("FAIL alu_decode: got %b want %b", outs, O_DEC); end
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_ADD_R) begin n_fail++; $display("FAIL alu_exec: got %b want %b", outs, O_ADD_R); end
        step();
        wb = {bus.reg_we, bus.mem_rd, bus.mem_wr, bus.ir_load, bus.pc_inc, bus.pc_load,
              bus.MA, bus.halted, bus.fault};
        n_cmp++;
        if (wb !== 9'b1_0000_0000) begin n_fail++; $display("FAIL alu_wb: got %b want %b", wb, 9'b1_0000_0000); end
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL alu_refetch: got %b want %b", outs, O_FETCH); end
        // NOP with run dropped: instruction completes, then IDLE.
        bus.run       = 1'b0;
        bus.instr     = 8'h00;
        bus.mem_ready = 1'b1;
        step();
        n_cmp++;
        if (outs !== O_DEC) begin n_fail++; $display("FAIL nop_decode: got %b want %b", outs, O_DEC); end
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL nop_to_idle: got %b want %b", outs, O_IDLE); end
        step();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL idle_hold: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'h2C;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_SUB_I) begin n_fail++; $display("FAIL sub_imm_exec: got %b want %b", outs, O_SUB_I); end
        step();
        n_cmp++;
        if (bus.reg_we !== 1'b1) begin n_fail++; $display("FAIL sub_wb: got %b want 1", bus.reg_we); end
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL b2b_fetch: got %b want %b", outs, O_FETCH); end
        bus.instr     = 8'h13;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_ADD_R) begin n_fail++; $display("FAIL b2b_add_exec: got %b want %b", outs, O_ADD_R); end
    endtask

    task automatic test_jump();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'h80;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_JUMP) begin n_fail++; $display("FAIL jz_taken: got %b want %b", outs, O_JUMP); end
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL jz_taken_exit: got %b want %b", outs, O_FETCH); end
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL jz_not_taken: got %b want %b", outs, O_IDLE); end
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL jz_nt_exit: got %b want %b", outs, O_FETCH); end
        bus.instr     = 8'h70;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        bus.run       = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_JUMP) begin n_fail++; $display("FAIL jmp_exec: got %b want %b", outs, O_JUMP); end
        step();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL jmp_run_low_idle: got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_store();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'h65;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_ST) begin n_fail++; $display("FAIL st_mem: got %b want %b", outs, O_ST); end
        step();
        n_cmp++;
        if (outs !== O_ST) begin n_fail++; $display("FAIL st_hold: got %b want %b", outs, O_ST); end
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL st_done: got %b want %b", outs, O_FETCH); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'h50;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_LD) begin n_fail++; $display("FAIL ld_mem: got %b want %b", outs, O_LD); end
        for (int i = 0; i < 14; i++) step();
        n_cmp++;
        if (outs !== O_LD) begin n_fail++; $display("FAIL ld_last_wait: got %b want %b", outs, O_LD); end
        step();
        n_cmp++;
        if (outs !== O_HALTF) begin n_fail++; $display("FAIL ld_timeout: got %b want %b", outs, O_HALTF); end
        bus.run = 1'b0;
        step();
        bus.run = 1'b1;
        step();
        step();
        n_cmp++;
        if (outs !== O_HALTF) begin n_fail++; $display("FAIL fault_no_resume: got %b want %b", outs, O_HALTF); end
    endtask

    task automatic test_ld_boundary();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'h50;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        for (int i = 0; i < 14; i++) step();
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (outs !== O_WB_LD) begin n_fail++; $display("FAIL ld_late_ready: got %b want %b", outs, O_WB_LD); end
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL ld_wb_exit: got %b want %b", outs, O_FETCH); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'hA0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_HALTF) begin n_fail++; $display("FAIL illegal_halt: got %b want %b", outs, O_HALTF); end
        step();
        n_cmp++;
        if (outs !== O_HALTF) begin n_fail++; $display("FAIL illegal_hold: got %b want %b", outs, O_HALTF); end
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'hF0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_HALT) begin n_fail++; $display("FAIL hlt_halt: got %b want %b", outs, O_HALT); end
        step();
        n_cmp++;
        if (outs !== O_HALT) begin n_fail++; $display("FAIL hlt_run_level: got %b want %b", outs, O_HALT); end
        bus.run = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_HALT) begin n_fail++; $display("FAIL hlt_run_low: got %b want %b", outs, O_HALT); end
        bus.run = 1'b1;
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL hlt_resume: got %b want %b", outs, O_FETCH); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        bus.run = 1'b1;
        step();
        bus.instr     = 8'h65;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        n_cmp++;
        if (outs !== O_ST) begin n_fail++; $display("FAIL pre_reset_st: got %b want %b", outs, O_ST); end
        #2;
        rst_n   = 1'b0;
        bus.run = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL async_reset: got %b want %b", outs, O_IDLE); end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (outs !== O_IDLE) begin n_fail++; $display("FAIL post_reset_idle: got %b want %b", outs, O_IDLE); end
        bus.run = 1'b1;
        step();
        n_cmp++;
        if (outs !== O_FETCH) begin n_fail++; $display("FAIL post_reset_fetch: got %b want %b", outs, O_FETCH); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_jump();
        test_store();
        test_timeout();
        test_ld_boundary();
        test_halt();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
